fifo_merge2: RTL and testbench
==============================

Name: fifo_merge2

Overview:
- Two-writer, one-reader FIFO; the converging counterpart of the broadcast two-reader queue.
- Two independent upstream producers (A, B) push into one shared in-order queue.
- A single downstream consumer pops from it.
- Sits where two data streams of equal width are funnelled into one sink; both writes are accepted in one cycle when space allows.

Parameters:
D_WIDTH, 6, data word width in bits
DEPTH, 8, number of entries; power of 2, minimum 4

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
up_data_a  input  D_WIDTH  producer A data
push_a  input  1  producer A write strobe
up_data_b  input  D_WIDTH  producer B data
push_b  input  1  producer B write strobe
pop  input  1  consumer read strobe; removes head entry
down_data  output  D_WIDTH  registered head-of-queue value
empty  output  1  level == 0
full  output  1  level == DEPTH
level  output  $clog2(DEPTH)+1  current number of stored entries
drop_a  output  1  one-cycle pulse: push_a rejected this edge
drop_b  output  1  one-cycle pulse: push_b rejected this edge

Behaviour:
- Reset, asynchronous on rst falling:
  - Pointers and level = 0; empty = 1, full = 0.
  - down_data = 0; drop_a = drop_b = 0.
  - Memory contents are not cleared.
- All decisions use level sampled before the edge (L). A pop never frees space for a push in the same cycle.
- Pop: honoured iff pop && L != 0. Pop when empty is ignored, with no flag.
- Push acceptance, A has priority:
  - push_a accepted iff L < DEPTH.
  - push_b accepted iff L + (push_a accepted) < DEPTH.
  - A rejected push asserts the matching drop_x for exactly the cycle after that edge; its data is discarded.
- Ordering when both are accepted in one cycle: A's word is written at wr_ptr, B's at wr_ptr+1; wr_ptr advances by 2.
- Pointers: wrap modulo DEPTH (log2(DEPTH)-bit, natural wrap).
- Level: level_next = L + acc_a + acc_b − pop_ok. Range 0..DEPTH, never exceeds DEPTH.
- down_data:
  - Registered on every edge to the head entry after that edge's pushes and pops are applied.
  - Set to 0 when the resulting level is 0.
  - A word pushed into an empty queue is visible on down_data one cycle after its push edge, together with empty = 0.
- Simultaneous cases:
  - push_a + push_b + pop with L = DEPTH−1: A accepted, B dropped, head popped; level_next = DEPTH−1.
  - push_a + push_b with L = 0: level_next = 2, down_data = A's word.
  - pop + push_x with L = 1: old head removed; down_data = the pushed word.
- Reset asserted mid-operation: all state clears immediately. In-flight pushes and pops on that edge have no effect. drop pulses clear.

Optional Feature:
- Macro: FIFO_MERGE2_DROP_CNT_EN
- When defined:
  - Adds output drop_cnt [7:0], reset to 0.
  - Increments by drop_a + drop_b events per edge (0, 1 or 2), saturating at 255.
  - Cleared only by rst.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push_a with 0x05 for one cycle -> next cycle empty = 0, level = 1, down_data = 0x05; pop one cycle -> empty = 1, down_data = 0.
- push_a = 0x11 and push_b = 0x22 in the same cycle, then pop twice -> down_data sequence 0x11, then 0x22, then 0 with empty = 1; level goes 2, 1, 0.
- DEPTH = 8: fill to level 7, then push_a = 0x2A and push_b = 0x15 together -> level = 8, full = 1, drop_b pulses once, drop_a = 0; draining yields 0x2A as the last word.
- At full, push_a + pop in the same cycle -> drop_a = 1, level = 7; with FIFO_MERGE2_DROP_CNT_EN, drop_cnt increments by 1.
- Random A/B pushes and pops over 2000 cycles with DEPTH = 8, compared against a queue model (A before B per cycle) -> down_data, level, empty, full and drops match every cycle, including multiple pointer wraps.
- Hold level = 5, assert rst low mid-cycle -> outputs go to reset values immediately without a clock edge; after release, the first push reads back correctly and no stale data appears.

Source files
------------

// File: rtl/fifo_merge2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_merge2 : two-writer (A priority, A before B), one-reader in-order FIFO |
// | Optional FIFO_MERGE2_DROP_CNT_EN adds a saturating drop_cnt. Rev 1.0        |
// +----------------------------------------------------------------------------+
module fifo_merge2 #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_WIDTH-1:0]       up_data_a,
  input  logic                     push_a,
  input  logic [D_WIDTH-1:0]       up_data_b,
  input  logic                     push_b,
  input  logic                     pop,
  output logic [D_WIDTH-1:0]       down_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_a,
  output logic                     drop_b
`ifdef FIFO_MERGE2_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, wr_ptr_b;
  logic [LW-1:0]      level_q, level_d, remain;
  logic [D_WIDTH-1:0] down_data_q, down_data_d;
  logic               drop_a_q, drop_a_d;
  logic               drop_b_q, drop_b_d;
  logic               pop_ok, acc_a, acc_b;

  // Every decision uses the pre-edge level, so a pop never makes room for a push.
  always_comb begin
    pop_ok   = pop && (level_q != '0);
    acc_a    = push_a && (level_q < LW'(DEPTH));
    acc_b    = push_b && ((level_q + LW'(acc_a)) < LW'(DEPTH));
    drop_a_d = push_a && !acc_a;
    drop_b_d = push_b && !acc_b;
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_b = wr_ptr_q + PW'(acc_a);
    wr_ptr_d = wr_ptr_b + PW'(acc_b);
    level_d  = level_q + LW'(acc_a) + LW'(acc_b) - LW'(pop_ok);
    remain   = level_q - LW'(pop_ok);
    // With no surviving old entry the new head is the word written this edge.
    if (level_d == '0)
      down_data_d = '0;
    else if (remain == '0)
      down_data_d = acc_a ? up_data_a : up_data_b;
    else
      down_data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst && acc_a) mem_q[wr_ptr_q] <= up_data_a;
    if (rst && acc_b) mem_q[wr_ptr_b] <= up_data_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      down_data_q <= '0;
      drop_a_q    <= 1'b0;
      drop_b_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      down_data_q <= down_data_d;
      drop_a_q    <= drop_a_d;
      drop_b_q    <= drop_b_d;
    end
  end

  assign down_data = down_data_q;
  assign level     = level_q;
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign drop_a    = drop_a_q;
  assign drop_b    = drop_b_q;

`ifdef FIFO_MERGE2_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] cnt_sum;

  always_comb begin
    cnt_sum    = {1'b0, drop_cnt_q} + 9'(drop_a_d) + 9'(drop_b_d);
    drop_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_merge2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_merge2 : directed + random scoreboard bench for fifo_merge2         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fifo_merge2;

  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] up_data_a = '0;
  logic          push_a = 1'b0;
  logic [DW-1:0] up_data_b = '0;
  logic          push_b = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] down_data;
  logic          empty, full, drop_a, drop_b;
  logic [LW-1:0] level;
`ifdef FIFO_MERGE2_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];
  int exp_cnt = 0;

  fifo_merge2 #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_data_a (up_data_a),
    .push_a    (push_a),
    .up_data_b (up_data_b),
    .push_b    (push_b),
    .pop       (pop),
    .down_data (down_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .drop_a    (drop_a),
    .drop_b    (drop_b)
`ifdef FIFO_MERGE2_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_da, input logic exp_db);
    logic [DW-1:0] exp_head;
    exp_head = (sb.size() != 0) ? sb[0] : '0;
    check({tag, ".down_data"}, 32'(down_data), 32'(exp_head));
    check({tag, ".level"},     32'(level),     32'(sb.size()));
    check({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
    check({tag, ".full"},      32'(full),      32'(sb.size() == DEPTH));
    check({tag, ".drop_a"},    32'(drop_a),    32'(exp_da));
    check({tag, ".drop_b"},    32'(drop_b),    32'(exp_db));
`ifdef FIFO_MERGE2_DROP_CNT_EN
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(exp_cnt));
`endif
  endtask

  // One clock of stimulus; the scoreboard is updated with pre-edge level.
  task automatic step(input string tag, input logic pa, input logic [DW-1:0] da,
                      input logic pb, input logic [DW-1:0] db, input logic pp);
    int  l;
    logic pok, aa, ab;
    push_a = pa; up_data_a = da; push_b = pb; up_data_b = db; pop = pp;
    l   = sb.size();
    pok = pp && (l != 0);
    aa  = pa && (l < DEPTH);
    ab  = pb && ((l + int'(aa)) < DEPTH);
    if (pok) void'(sb.pop_front());
    if (aa) sb.push_back(da);
    if (ab) sb.push_back(db);
    exp_cnt = exp_cnt + int'(pa && !aa) + int'(pb && !ab);
    if (exp_cnt > 255) exp_cnt = 255;
    @(posedge clk);
    #1;
    check_all(tag, pa && !aa, pb && !ab);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".down_data"}, 32'(down_data), 32'h0);
    check({tag, ".level"},     32'(level),     32'h0);
    check({tag, ".empty"},     32'(empty),     32'h1);
    check({tag, ".full"},      32'(full),      32'h0);
    check({tag, ".drop_a"},    32'(drop_a),    32'h0);
    check({tag, ".drop_b"},    32'(drop_b),    32'h0);
`ifdef FIFO_MERGE2_DROP_CNT_EN
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'h0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b1;

    // Single push then pop.
    step("pushA05", 1'b1, 6'h05, 1'b0, 6'h00, 1'b0);
    step("pop05",   1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    step("popEmpty",1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    // Dual push ordering.
    step("pushAB",  1'b1, 6'h11, 1'b1, 6'h22, 1'b0);
    step("popAB1",  1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    step("popAB2",  1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    // Pop and push at level 1.
    step("lvl1",    1'b0, 6'h00, 1'b1, 6'h33, 1'b0);
    step("popPush", 1'b1, 6'h0C, 1'b0, 6'h00, 1'b1);
    step("drain1",  1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    // Fill to 7, then A+B: B dropped.
    for (int i = 0; i < 3; i++)
      step("fill", 1'b1, DW'(2 * i + 1), 1'b1, DW'(2 * i + 2), 1'b0);
    step("fill7",   1'b1, 6'h07, 1'b0, 6'h00, 1'b0);
    step("dropB",   1'b1, 6'h2A, 1'b1, 6'h15, 1'b0);
    step("fullIdle",1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    // At full: A dropped even though a pop happens.
    step("dropApop",1'b1, 6'h3F, 1'b0, 6'h00, 1'b1);
    // At 7: A, B, pop -> A in, B out.
    step("abPop7",  1'b1, 6'h1E, 1'b1, 6'h1F, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      step("drain", 1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    // Random traffic with phases biased towards filling and draining.
    for (int i = 0; i < 2000; i++) begin
      logic fill_phase;
      fill_phase = ((i / 64) % 2) == 0;
      step("rand",
           ($urandom_range(0, 99) < (fill_phase ? 70 : 30)), DW'($urandom),
           ($urandom_range(0, 99) < (fill_phase ? 60 : 25)), DW'($urandom),
           ($urandom_range(0, 99) < (fill_phase ? 30 : 75)));
    end
    for (int i = 0; i < DEPTH; i++)
      step("rdrain", 1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    // Mid-cycle asynchronous reset at level 5.
    step("pre5a", 1'b1, 6'h01, 1'b1, 6'h02, 1'b0);
    step("pre5b", 1'b1, 6'h03, 1'b1, 6'h04, 1'b0);
    step("pre5c", 1'b1, 6'h05, 1'b1, 6'h06, 1'b1);
    push_a = 1'b1; push_b = 1'b1; pop = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    exp_cnt = 0;
    check_reset_vals("asyncRst");
    @(posedge clk);
    #1;
    check_reset_vals("rstHeld");
    @(negedge clk);
    rst = 1'b1;
    step("postRst", 1'b1, 6'h2D, 1'b0, 6'h00, 1'b0);
    step("postPop", 1'b0, 6'h00, 1'b0, 6'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
